// File: rtl/mcu_debug_responder_if.sv
// Debugger command bus plus core-side register-file/memory ports of the debug responder.
// The responder takes the slave view; the debugger/core environment takes the master view.
interface mcu_debug_responder_if;
    logic        valid;
    logic        pause;
    logic        resume;
    logic        dbg_reset;
    logic        reg_rd;
    logic        reg_wr;
    logic        mem_rd;
    logic        mem_wr;
    logic        mem_rw_byte;
    logic [31:0] addr;
    logic [31:0] d_in;
    logic [31:0] d_rd;
    logic [31:0] pc;
    logic        mcu_busy;
    logic        error;
    logic [31:0] core_pc;
    logic        core_halted;
    logic        core_stall;
    logic        core_reset;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wd;
    logic        rf_we;
    logic [31:0] rf_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [3:0]  mem_be;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  valid, pause, resume, dbg_reset, reg_rd, reg_wr, mem_rd, mem_wr,
        input  mem_rw_byte, addr, d_in, core_pc, core_halted, rf_rdata, mem_rdata, mem_ack,
        output d_rd, pc, mcu_busy, error, core_stall, core_reset,
        output rf_addr, rf_wd, rf_we, mem_addr, mem_wd, mem_be, mem_re, mem_we
    );

    modport master (
        output valid, pause, resume, dbg_reset, reg_rd, reg_wr, mem_rd, mem_wr,
        output mem_rw_byte, addr, d_in, core_pc, core_halted, rf_rdata, mem_rdata, mem_ack,
        input  d_rd, pc, mcu_busy, error, core_stall, core_reset,
        input  rf_addr, rf_wd, rf_we, mem_addr, mem_wd, mem_be, mem_re, mem_we
    );
endinterface

// File: rtl/mcu_debug_responder.sv
// Debug responder: stalls the core and runs one register/memory access per command; reg ops take 2 cycles,
// mem ops ack+1 (abort after TIMEOUT). No backpressure: commands arriving while busy are dropped with an error pulse.
module mcu_debug_responder #(
    parameter int TIMEOUT      = 255,
    parameter int RESET_CYCLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    mcu_debug_responder_if.slave dbg
);
    localparam int MAXC = (TIMEOUT > RESET_CYCLES) ? TIMEOUT : RESET_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        ST_RUN, ST_HALTING, ST_HALTED, ST_REG_ACC, ST_MEM_WAIT, ST_RESETTING
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic          r_busy, w_busy_nxt;
    logic          r_error, w_error_nxt;
    logic          r_stall, w_stall_nxt;
    logic          r_core_rst, w_core_rst_nxt;
    logic [31:0]   r_d_rd, w_d_rd_nxt;
    logic [31:0]   r_pc, w_pc_nxt;
    logic          r_rd, w_rd_nxt;
    logic          r_byte, w_byte_nxt;
    logic [1:0]    r_lane, w_lane_nxt;
    logic [4:0]    r_rf_addr, w_rf_addr_nxt;
    logic [31:0]   r_rf_wd, w_rf_wd_nxt;
    logic          r_rf_we, w_rf_we_nxt;
    logic [31:0]   r_mem_addr, w_mem_addr_nxt;
    logic [31:0]   r_mem_wd, w_mem_wd_nxt;
    logic [3:0]    r_mem_be, w_mem_be_nxt;
    logic          r_mem_re, w_mem_re_nxt;
    logic          r_mem_we, w_mem_we_nxt;

    logic [6:0]    w_sel;
    logic [7:0]    w_lane_dat;

    assign w_sel      = {dbg.pause, dbg.resume, dbg.dbg_reset, dbg.reg_rd, dbg.reg_wr, dbg.mem_rd, dbg.mem_wr};
    assign w_lane_dat = dbg.mem_rdata[{r_lane, 3'b000} +: 8];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ST_RUN;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_error    <= 1'b0;
            r_stall    <= 1'b0;
            r_core_rst <= 1'b0;
            r_d_rd     <= '0;
            r_pc       <= '0;
            r_rd       <= 1'b0;
            r_byte     <= 1'b0;
            r_lane     <= '0;
            r_rf_addr  <= '0;
            r_rf_wd    <= '0;
            r_rf_we    <= 1'b0;
            r_mem_addr <= '0;
            r_mem_wd   <= '0;
            r_mem_be   <= '0;
            r_mem_re   <= 1'b0;
            r_mem_we   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_busy     <= w_busy_nxt;
            r_error    <= w_error_nxt;
            r_stall    <= w_stall_nxt;
            r_core_rst <= w_core_rst_nxt;
            r_d_rd     <= w_d_rd_nxt;
            r_pc       <= w_pc_nxt;
            r_rd       <= w_rd_nxt;
            r_byte     <= w_byte_nxt;
            r_lane     <= w_lane_nxt;
            r_rf_addr  <= w_rf_addr_nxt;
            r_rf_wd    <= w_rf_wd_nxt;
            r_rf_we    <= w_rf_we_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_mem_wd   <= w_mem_wd_nxt;
            r_mem_be   <= w_mem_be_nxt;
            r_mem_re   <= w_mem_re_nxt;
            r_mem_we   <= w_mem_we_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_error_nxt    = 1'b0;
        w_stall_nxt    = r_stall;
        w_core_rst_nxt = r_core_rst;
        w_d_rd_nxt     = r_d_rd;
        w_pc_nxt       = (r_state == ST_RUN) ? dbg.core_pc : r_pc;
        w_rd_nxt       = r_rd;
        w_byte_nxt     = r_byte;
        w_lane_nxt     = r_lane;
        w_rf_addr_nxt  = '0;
        w_rf_wd_nxt    = '0;
        w_rf_we_nxt    = 1'b0;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_wd_nxt   = r_mem_wd;
        w_mem_be_nxt   = r_mem_be;
        w_mem_re_nxt   = r_mem_re;
        w_mem_we_nxt   = r_mem_we;

        case (r_state)
            ST_RUN, ST_HALTED: begin
                if (dbg.valid) begin
                    if (!$onehot(w_sel)) begin
                        w_error_nxt = 1'b1;
                    end else if (dbg.pause) begin
                        if (r_state == ST_RUN) begin
                            w_stall_nxt = 1'b1;
                            w_state_nxt = ST_HALTING;
                        end
                    end else if (dbg.resume) begin
                        if (r_state == ST_HALTED) begin
                            w_stall_nxt = 1'b0;
                            w_state_nxt = ST_RUN;
                        end
                    end else if (dbg.dbg_reset) begin
                        w_stall_nxt    = 1'b0;
                        w_core_rst_nxt = 1'b1;
                        w_cnt_nxt      = CW'(1);
                        w_state_nxt    = ST_RESETTING;
                    end else if (r_state != ST_HALTED) begin
                        w_error_nxt = 1'b1;
                    end else if (dbg.reg_rd || dbg.reg_wr) begin
                        if (dbg.addr[31:5] != '0) begin
                            w_error_nxt = 1'b1;
                        end else begin
                            w_state_nxt   = ST_REG_ACC;
                            w_rd_nxt      = dbg.reg_rd;
                            w_rf_addr_nxt = dbg.addr[4:0];
                            w_rf_wd_nxt   = dbg.reg_wr ? dbg.d_in : '0;
                            // x0 is hardwired; the write is silently dropped
                            w_rf_we_nxt   = dbg.reg_wr && (dbg.addr[4:0] != 5'd0);
                        end
                    end else if (!dbg.mem_rw_byte && (dbg.addr[1:0] != 2'b00)) begin
                        w_error_nxt = 1'b1;
                    end else begin
                        w_state_nxt    = ST_MEM_WAIT;
                        w_cnt_nxt      = CW'(1);
                        w_byte_nxt     = dbg.mem_rw_byte;
                        w_lane_nxt     = dbg.addr[1:0];
                        w_mem_addr_nxt = {dbg.addr[31:2], 2'b00};
                        w_mem_be_nxt   = dbg.mem_rw_byte ? (4'b0001 << dbg.addr[1:0]) : 4'b1111;
                        w_mem_wd_nxt   = dbg.mem_wr ? (dbg.mem_rw_byte ? {4{dbg.d_in[7:0]}} : dbg.d_in) : '0;
                        w_mem_re_nxt   = dbg.mem_rd;
                        w_mem_we_nxt   = dbg.mem_wr;
                    end
                end
            end
            ST_HALTING: begin
                if (dbg.core_halted) w_state_nxt = ST_HALTED;
            end
            ST_REG_ACC: begin
                if (r_rd) w_d_rd_nxt = dbg.rf_rdata;
                w_state_nxt = ST_HALTED;
            end
            ST_MEM_WAIT: begin
                if (dbg.mem_ack || (r_cnt == CW'(TIMEOUT))) begin
                    if (dbg.mem_ack && r_mem_re) begin
                        w_d_rd_nxt = r_byte ? {24'd0, w_lane_dat} : dbg.mem_rdata;
                    end
                    w_error_nxt    = !dbg.mem_ack;
                    w_state_nxt    = ST_HALTED;
                    w_mem_addr_nxt = '0;
                    w_mem_wd_nxt   = '0;
                    w_mem_be_nxt   = '0;
                    w_mem_re_nxt   = 1'b0;
                    w_mem_we_nxt   = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_RESETTING: begin
                if (r_cnt == CW'(RESET_CYCLES)) begin
                    w_core_rst_nxt = 1'b0;
                    w_state_nxt    = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase

        if (dbg.valid && (r_state != ST_RUN) && (r_state != ST_HALTED)) w_error_nxt = 1'b1;

        w_busy_nxt = (w_state_nxt == ST_HALTING) || (w_state_nxt == ST_REG_ACC) ||
                     (w_state_nxt == ST_MEM_WAIT) || (w_state_nxt == ST_RESETTING);
    end

    assign dbg.d_rd       = r_d_rd;
    assign dbg.pc         = r_pc;
    assign dbg.mcu_busy   = r_busy;
    assign dbg.error      = r_error;
    assign dbg.core_stall = r_stall;
    assign dbg.core_reset = r_core_rst;
    assign dbg.rf_addr    = r_rf_addr;
    assign dbg.rf_wd      = r_rf_wd;
    assign dbg.rf_we      = r_rf_we;
    assign dbg.mem_addr   = r_mem_addr;
    assign dbg.mem_wd     = r_mem_wd;
    assign dbg.mem_be     = r_mem_be;
    assign dbg.mem_re     = r_mem_re;
    assign dbg.mem_we     = r_mem_we;
endmodule

// File: doc/mcu_debug_responder.md
# mcu_debug_responder

MCU-side endpoint of the debug control interface. It accepts single-cycle debugger commands: pause, resume, reset, register read/write, and memory read/write. It stalls the core, performs the requested register-file or memory access through dedicated core-side ports, and returns read data, the program counter, busy status and error pulses. It sits inside the MCU between the debug controller and the core datapath.

## Interface
- TIMEOUT, default 255: max cycles waiting for mem_ack before abort.
- RESET_CYCLES, default 4: length of the core_reset pulse.
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- valid  in  1  one-cycle command strobe
- pause, resume, dbg_reset, reg_rd, reg_wr, mem_rd, mem_wr  in  1 each  command selects, sampled with valid
- mem_rw_byte  in  1  1 = byte access, 0 = word access
- addr  in  32  register index (bits 4:0) or byte address
- d_in  in  32  write data
- d_rd  out  32  read data to debugger
- pc  out  32  registered core PC
- mcu_busy  out  1  responder executing a command
- error  out  1  one-cycle error pulse
- core_pc  in  32  live core PC
- core_halted  in  1  core stopped at an instruction boundary
- core_stall  out  1  halt request to core
- core_reset  out  1  core reset pulse
- rf_addr  out  5;  rf_wd  out  32;  rf_we  out  1;  rf_rdata  in  32
- mem_addr  out  32;  mem_wd  out  32;  mem_be  out  4;  mem_re, mem_we  out  1;  mem_rdata  in  32;  mem_ack  in  1

## Operation
- States: RUN, HALTING, HALTED, REG_ACC, MEM_WAIT, RESETTING.
- mcu_busy = 1 in HALTING, REG_ACC, MEM_WAIT and RESETTING. It is registered, so it rises the cycle after an accepted valid.
- Command acceptance. A valid is accepted only in RUN or HALTED with exactly one select high. Any of the following drops the command and pulses error the next cycle:
  - zero or more than one select high;
  - valid while busy;
  - any register or memory command outside HALTED.
- pause in RUN: core_stall goes to 1 and the block enters HALTING. It moves to HALTED on the first cycle core_halted = 1. pause in HALTED is a no-op with no error.
- resume in HALTED: core_stall goes to 0 and the block enters RUN. resume in RUN is a no-op.
- dbg_reset, accepted in RUN or HALTED:
  - enters RESETTING and holds core_reset = 1 for RESET_CYCLES cycles;
  - core_stall is cleared;
  - then enters RUN.
- reg_rd and reg_wr:
  - addr[31:5] must be 0, otherwise error and no access.
  - The block spends one cycle in REG_ACC with rf_addr = addr[4:0].
  - rd: d_rd is loaded with rf_rdata at the end of REG_ACC.
  - wr: rf_wd = d_in. rf_we = 1 for that one cycle unless the index is 0; writes to x0 are suppressed without error.
- mem_rd and mem_wr:
  - Word access requires addr[1:0] = 0, otherwise error and no access.
  - mem_addr = {addr[31:2], 2'b00}.
  - Word: mem_be = 4'b1111.
  - Byte: mem_be is one-hot at lane addr[1:0], and mem_wd replicates d_in[7:0] in all four lanes.
  - mem_re or mem_we is held in MEM_WAIT until mem_ack = 1.
  - Read: d_rd = mem_rdata (word), or the selected byte lane zero-extended (byte), captured on the ack cycle.
- Memory timeout: if no ack arrives within TIMEOUT cycles, the strobes drop, error pulses, d_rd is unchanged and the block returns to HALTED.
- Return state: register and memory commands always return to HALTED.
- pc: loaded from core_pc every cycle in RUN. It holds its value in every other state.
- d_rd holds its value until the next successful read.
- Reset values: state RUN; d_rd, pc, mcu_busy, error, core_stall and core_reset all 0; all rf_* and mem_* outputs 0.

## Timing
- Let T be the cycle in which valid is sampled (accepted on the rising edge at the end of T).
- Error pulse is in cycle T+1.
- reg_rd: REG_ACC in T+1. In T+2, d_rd is valid and mcu_busy = 0.
- reg_wr: rf_we is high only in T+1. mcu_busy is low in T+2.
- mem: strobes run from T+1 through the ack cycle A. In A+1, d_rd is valid, strobes are 0 and mcu_busy = 0. Minimum latency is 2 cycles, when ack arrives in T+1.
- Timeout: strobes are high for TIMEOUT cycles, T+1 through T+TIMEOUT. error = 1 in T+TIMEOUT+1.
- pause: core_stall rises in T+1. HALTED is entered the cycle after core_halted is sampled high.
- core_halted already high at acceptance: HALTED is entered in T+2.
- dbg_reset: core_reset is high in T+1 through T+RESET_CYCLES. State is RUN in the following cycle.
- reset_n asserted mid-operation: all state and outputs clear immediately, including the memory strobes, and no error is emitted.

## Test plan
- Pause/resume:
  - Stimulus: core_pc = 0x100, pause; core_halted rises 3 cycles later; then resume.
  - Required: core_stall = 1 from T+1; mcu_busy high until HALTED; pc frozen at 0x100 while core_pc changes; core_stall = 0 after resume.
- Register access when halted:
  - reg_wr addr 5, d_in 0xDEADBEEF → rf_we pulses once with rf_addr = 5.
  - reg_rd addr 5 with rf_rdata = 0xDEADBEEF → d_rd = 0xDEADBEEF at T+2.
  - reg_wr addr 0 → no rf_we, no error.
- Memory byte and word access:
  - Byte write addr 0x1003, d_in 0xA5 → mem_addr = 0x1000, mem_be = 4'b1000, mem_wd = 0xA5A5A5A5.
  - Byte read addr 0x1001 with mem_rdata = 0x11223344 → d_rd = 0x00000033.
  - Word read with ack delayed 5 cycles → d_rd valid at A+1.
- Illegal commands:
  - reg_rd while in RUN → error, no access.
  - Word read at addr 0x1002 → error.
  - valid with pause and reset both high → error.
  - valid while busy → error, and the in-flight command completes normally.
- Timeout and reset:
  - mem_rd with mem_ack never asserted, TIMEOUT = 8 → error at T+9, state returns to HALTED.
  - dbg_reset → core_reset high for exactly 4 cycles, then RUN.
  - reset_n pulsed during MEM_WAIT → all outputs 0.
